// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and FSM state encoding
//
// Purpose: shared constants for the raster timing generator.
//   DEF_*       : VESA 640x480@60 timing fields, pixel divider and counter width
//   vga_state_e : scan FSM encoding (IDLE = 0, ACTIVE = 1)

package vga_pkg;

  localparam int DEF_HD      = 640;
  localparam int DEF_HFP     = 16;
  localparam int DEF_HSW     = 96;
  localparam int DEF_HBP     = 48;
  localparam int DEF_VD      = 480;
  localparam int DEF_VFP     = 10;
  localparam int DEF_VSW     = 2;
  localparam int DEF_VBP     = 33;
  localparam int DEF_HS_POL  = 0;
  localparam int DEF_VS_POL  = 0;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_CW      = 11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } vga_state_e;

endpackage

// File: rtl/pix_tick_div.sv
// rtl/pix_tick_div.sv - pixel clock-enable divider on the single clock domain
//
// Purpose: produces a one-clk pixel enable every CLK_DIV clks.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   pix_tick : registered pixel enable, first high CLK_DIV clks after reset release

module pix_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic          r_pix_tick;

  // The enable is registered from the terminal count, so it lands one clk
  // after div_cnt reaches its last value; with CLK_DIV = 1 this keeps the
  // enable low while reset is held and high on every clk afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      r_pix_tick <= (r_div_cnt == DIV_LAST);
      r_div_cnt  <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
    end
  end

  assign pix_tick = r_pix_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with run/stop
//
// Purpose: generates x/y counters, video_on, syncs and line/frame strobes on a
// pixel clock-enable. Scanning stops only at a frame boundary.
// Ports:
//   clk_50MHz   : sole clock, rising edge
//   rst         : synchronous active-high reset
//   run         : request scanning (sampled on tick edges)
//   pix_tick    : pixel enable, one clk wide
//   x, y        : horizontal / vertical position
//   video_on    : inside the active area
//   hsync/vsync : syncs at HS_POL / VS_POL active level
//   line_start  : one-clk strobe when x = 0 is presented while scanning
//   frame_start : one-clk strobe when (0,0) is presented while scanning
//   busy        : FSM in ACTIVE
//   frame_cnt   : frame counter, present only with VGA_TIMING_FRAME_CNT_EN

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HD      = DEF_HD,
  parameter int HFP     = DEF_HFP,
  parameter int HSW     = DEF_HSW,
  parameter int HBP     = DEF_HBP,
  parameter int VD      = DEF_VD,
  parameter int VFP     = DEF_VFP,
  parameter int VSW     = DEF_VSW,
  parameter int VBP     = DEF_VBP,
  parameter int HS_POL  = DEF_HS_POL,
  parameter int VS_POL  = DEF_VS_POL,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CW      = DEF_CW
) (
  input  logic          clk_50MHz,
  input  logic          rst,
  input  logic          run,
  output logic          pix_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam logic [CW-1:0] HMAX     = CW'(HD + HFP + HSW + HBP - 1);
  localparam logic [CW-1:0] VMAX     = CW'(VD + VFP + VSW + VBP - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(HD);
  localparam logic [CW-1:0] V_ACT    = CW'(VD);
  localparam logic [CW-1:0] HS_START = CW'(HD + HFP);
  localparam logic [CW-1:0] HS_END   = CW'(HD + HFP + HSW - 1);
  localparam logic [CW-1:0] VS_START = CW'(VD + VFP);
  localparam logic [CW-1:0] VS_END   = CW'(VD + VFP + VSW - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic          w_pix_tick;
  vga_state_e    r_state;
  vga_state_e    w_state_nxt;
  logic          w_frame_end;
  logic          w_act_nxt;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_video_on;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_line_start;
  logic          r_frame_start;

  logic [CW-1:0] w_x_nxt;
  logic [CW-1:0] w_y_nxt;
  logic          w_video_on_nxt;
  logic          w_hsync_nxt;
  logic          w_vsync_nxt;
  logic          w_line_start_nxt;
  logic          w_frame_start_nxt;

  pix_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_div (
    .clk      (clk_50MHz),
    .rst      (rst),
    .pix_tick (w_pix_tick)
  );

  assign w_frame_end = (r_x == HMAX) && (r_y == VMAX);

  // State register: the FSM only moves on tick edges.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (w_pix_tick) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: run is only looked at in IDLE and on the last pixel of a frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (run) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_frame_end && !run) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the counter values that will be presented after this
  // tick, so video_on/syncs/strobes always line up with the registered x/y.
  // Entry from IDLE keeps x = y = 0 for the first active pixel.
  always_comb begin
    w_x_nxt = '0;
    w_y_nxt = '0;
    if (r_state == ST_ACTIVE) begin
      if (r_x == HMAX) begin
        w_y_nxt = (r_y == VMAX) ? '0 : r_y + CW'(1);
      end else begin
        w_x_nxt = r_x + CW'(1);
        w_y_nxt = r_y;
      end
    end
    w_act_nxt         = (w_state_nxt == ST_ACTIVE);
    w_video_on_nxt    = w_act_nxt && (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
    w_hsync_nxt       = (w_act_nxt && (w_x_nxt >= HS_START) && (w_x_nxt <= HS_END)) ? HS_ON : ~HS_ON;
    w_vsync_nxt       = (w_act_nxt && (w_y_nxt >= VS_START) && (w_y_nxt <= VS_END)) ? VS_ON : ~VS_ON;
    w_line_start_nxt  = w_act_nxt && (w_x_nxt == '0);
    w_frame_start_nxt = w_line_start_nxt && (w_y_nxt == '0);
  end

  // Position/decode registers load on tick edges; strobes clear on every
  // other clk so they stay one clk wide for any CLK_DIV.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_video_on    <= 1'b0;
      r_hsync       <= ~HS_ON;
      r_vsync       <= ~VS_ON;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_pix_tick) begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_video_on    <= w_video_on_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_pix_tick && w_frame_start_nxt) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign pix_tick    = w_pix_tick;
  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = r_video_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign busy        = (r_state == ST_ACTIVE);

endmodule
